angle_ascii_framer: RTL and testbench

//   Downstream of bi_microphone, upstream of the UART transmitter.

---
 rtl/angle_ascii_framer_if.sv | 26 ++
 rtl/angle_ascii_framer.sv | 152 +++++++++++++++
 tb/tb_angle_ascii_framer.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/angle_ascii_framer_if.sv
// Purpose: byte-stream bundle between the angle source, the ASCII framer
//          and the UART transmitter.
// Signals: angle_in/angle_vld  - signed angle and its single-cycle strobe
//          tx_data/tx_vld/tx_rdy - ASCII byte handshake towards the UART
//          busy/frame_done/drop_cnt - framer status
// Modports: master drives the angle and tx_rdy; slave is the framer.
interface angle_ascii_framer_if;
  logic [15:0] angle_in;
  logic        angle_vld;
  logic [7:0]  tx_data;
  logic        tx_vld;
  logic        tx_rdy;
  logic        busy;
  logic        frame_done;
  logic [7:0]  drop_cnt;

  modport master (
    output angle_in, angle_vld, tx_rdy,
    input  tx_data, tx_vld, busy, frame_done, drop_cnt
  );

  modport slave (
    input  angle_in, angle_vld, tx_rdy,
    output tx_data, tx_vld, busy, frame_done, drop_cnt
  );
endinterface

// File: rtl/angle_ascii_framer.sv
// Purpose: turns each signed 16-bit angle into an ASCII decimal frame
//          (sign, 5 digits, optional CR LF) and streams it byte by byte.
// Ports:   clk  - system clock
//          rst  - asynchronous active-high reset
//          bus  - angle_ascii_framer_if.slave (angle strobe in, byte stream
//                 out, busy / frame_done / drop_cnt status)
//
// state | meaning
// IDLE  | waiting for angle_vld
// CONV  | serial double-dabble, 16 iterations then one hand-off clock
// SEND  | presenting bytes, index advances on tx_vld & tx_rdy
module angle_ascii_framer #(
  parameter bit         TERM_CRLF = 1'b1,
  parameter logic [7:0] PAD_CHAR  = 8'h30
) (
  input logic                  clk,
  input logic                  rst,
  angle_ascii_framer_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, CONV, SEND} state_t;

  localparam logic [2:0] LAST_IDX = TERM_CRLF ? 3'd7 : 3'd5;

  state_t      r_state;
  logic        r_sign;
  logic [15:0] r_mag;
  logic [19:0] r_bcd;
  logic [4:0]  r_cnt;
  logic [2:0]  r_idx;
  logic [7:0]  r_tx_data;
  logic        r_tx_vld;
  logic        r_busy;
  logic        r_frame_done;
  logic [7:0]  r_drop_cnt;

  logic        w_xfer;
  logic        w_last;
  logic        w_accept;
  logic        w_drop;
  logic [15:0] w_mag;
  logic [19:0] w_bcd_adj;

  assign w_xfer   = r_tx_vld & bus.tx_rdy;
  assign w_last   = w_xfer && (r_idx == LAST_IDX);
  // A strobe landing on the last-byte transfer starts the next frame directly.
  assign w_accept = bus.angle_vld && ((r_state == IDLE) || w_last);
  assign w_drop   = bus.angle_vld && !w_accept;
  // 16-bit unsigned magnitude already covers 32768, so -32768 needs no 17th bit.
  assign w_mag    = bus.angle_in[15] ? (16'd0 - bus.angle_in) : bus.angle_in;

  always_comb begin
    w_bcd_adj = r_bcd;
    for (int d = 0; d < 5; d++) begin
      if (r_bcd[d*4 +: 4] >= 4'd5)
        w_bcd_adj[d*4 +: 4] = r_bcd[d*4 +: 4] + 4'd3;
    end
  end

  function automatic logic [7:0] byte_for(input logic [2:0] idx,
                                          input logic [19:0] bcd,
                                          input logic sgn);
    logic [19:0] upper;
    int          sh;
    byte_for = 8'h00;
    upper    = '0;
    sh       = 0;
    case (idx)
      3'd0: byte_for = sgn ? 8'h2D : 8'h2B;
      3'd1, 3'd2, 3'd3, 3'd4, 3'd5: begin
        // upper holds this digit and every more-significant one; all zero
        // means a leading zero, except the units digit which always prints.
        sh    = (5 - int'(idx)) * 4;
        upper = bcd >> sh;
        if ((upper == 20'd0) && (idx != 3'd5)) byte_for = PAD_CHAR;
        else                                   byte_for = {4'h3, upper[3:0]};
      end
      3'd6:    byte_for = 8'h0D;
      default: byte_for = 8'h0A;
    endcase
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_sign       <= 1'b0;
      r_mag        <= '0;
      r_bcd        <= '0;
      r_cnt        <= '0;
      r_idx        <= '0;
      r_tx_data    <= '0;
      r_tx_vld     <= 1'b0;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
      r_drop_cnt   <= '0;
    end else begin
      r_frame_done <= w_last;
      if (w_drop && (r_drop_cnt != 8'hFF))
        r_drop_cnt <= r_drop_cnt + 8'd1;

      case (r_state)
        IDLE: ;
        CONV: begin
          if (r_cnt != 5'd0) begin
            r_bcd <= {w_bcd_adj[18:0], r_mag[15]};
            r_mag <= {r_mag[14:0], 1'b0};
            r_cnt <= r_cnt - 5'd1;
          end else begin
            r_state   <= SEND;
            r_idx     <= 3'd0;
            r_tx_vld  <= 1'b1;
            r_tx_data <= byte_for(3'd0, r_bcd, r_sign);
          end
        end
        SEND: begin
          if (w_xfer) begin
            if (r_idx == LAST_IDX) begin
              r_tx_vld <= 1'b0;
              r_state  <= IDLE;
              r_busy   <= 1'b0;
            end else begin
              r_idx     <= r_idx + 3'd1;
              r_tx_data <= byte_for(r_idx + 3'd1, r_bcd, r_sign);
            end
          end
        end
        default: begin
          r_state  <= IDLE;
          r_tx_vld <= 1'b0;
          r_busy   <= 1'b0;
        end
      endcase

      // Capture last so it overrides the SEND -> IDLE exit on back-to-back frames.
      if (w_accept) begin
        r_sign  <= bus.angle_in[15];
        r_mag   <= w_mag;
        r_bcd   <= '0;
        r_cnt   <= 5'd16;
        r_state <= CONV;
        r_busy  <= 1'b1;
      end
    end
  end

  assign bus.tx_data    = r_tx_data;
  assign bus.tx_vld     = r_tx_vld;
  assign bus.busy       = r_busy;
  assign bus.frame_done = r_frame_done;
  assign bus.drop_cnt   = r_drop_cnt;

endmodule

// File: tb/tb_angle_ascii_framer.sv
// Purpose: directed bench for angle_ascii_framer; dut_a uses the default
//          parameters, dut_b uses space padding without CR LF.
module tb_angle_ascii_framer;
  logic clk;
  logic rst;
  int   checks;
  int   failures;
  bit   cur_sel;

  angle_ascii_framer_if bus_a ();
  angle_ascii_framer_if bus_b ();

  angle_ascii_framer dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a.slave)
  );

  angle_ascii_framer #(.TERM_CRLF(1'b0), .PAD_CHAR(8'h20)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b.slave)
  );

  logic       vld_s;
  logic [7:0] data_s;
  logic       done_s;
  logic       busy_s;
  assign vld_s  = cur_sel ? bus_b.tx_vld     : bus_a.tx_vld;
  assign data_s = cur_sel ? bus_b.tx_data    : bus_a.tx_data;
  assign done_s = cur_sel ? bus_b.frame_done : bus_a.frame_done;
  assign busy_s = cur_sel ? bus_b.busy       : bus_a.busy;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_vld(input bit sel, input logic v);
    if (sel) bus_b.angle_vld = v;
    else     bus_a.angle_vld = v;
  endtask

  task automatic strobe(input bit sel, input logic [15:0] ang);
    @(negedge clk);
    bus_a.angle_in = ang;
    bus_b.angle_in = ang;
    set_vld(sel, 1'b1);
    @(negedge clk);
    set_vld(sel, 1'b0);
  endtask

  // exp is left-aligned: byte k is exp[63-8k -: 8]
  task automatic run_frame(input string tag, input bit sel, input bit do_strobe,
                           input logic [15:0] ang, input logic [63:0] exp,
                           input int n, input bit rnd, input bit chain,
                           input logic [15:0] chain_ang);
    int         cyc;
    int         got;
    int         stretch;
    int         extra;
    bit         prev_stall;
    logic [7:0] prev;
    logic [63:0] e;
    cur_sel = sel;
    e = exp;
    if (!rnd) bus_a.tx_rdy = 1'b1;
    if (!rnd) bus_b.tx_rdy = 1'b1;
    if (do_strobe) begin
      strobe(sel, ang);
      cyc = 0;
      while (!vld_s && cyc < 100) begin
        @(negedge clk);
        cyc++;
      end
      chk({tag, "_latency"}, cyc, 17);
    end
    got = 0; cyc = 0; stretch = 0; prev_stall = 0; prev = '0;
    while (got < n && cyc < 2000) begin
      if (prev_stall)
        chk({tag, "_stall_hold"}, {23'd0, vld_s, data_s}, {23'd0, 1'b1, prev});
      if (rnd) begin
        if (stretch > 0) begin
          bus_a.tx_rdy = 1'b0; stretch--;
        end else if ($urandom_range(0, 7) == 0) begin
          bus_a.tx_rdy = 1'b0; stretch = 9;
        end else begin
          bus_a.tx_rdy = 1'($urandom_range(0, 1));
        end
        bus_b.tx_rdy = bus_a.tx_rdy;
      end
      if (vld_s && (sel ? bus_b.tx_rdy : bus_a.tx_rdy)) begin
        chk($sformatf("%s_byte%0d", tag, got), {24'd0, data_s}, {24'd0, e[63 - 8*got -: 8]});
        got++;
        if (chain && got == n) begin
          bus_a.angle_in = chain_ang;
          bus_b.angle_in = chain_ang;
          set_vld(sel, 1'b1);
        end
        prev_stall = 1'b0;
      end else begin
        prev_stall = vld_s;
      end
      prev = data_s;
      @(negedge clk);
      set_vld(sel, 1'b0);
      cyc++;
    end
    chk({tag, "_count"}, got, n);
    chk({tag, "_done_pulse"}, {31'd0, done_s}, 32'd1);
    chk({tag, "_vld_after"}, {31'd0, vld_s}, 32'd0);
    chk({tag, "_busy_after"}, {31'd0, busy_s}, {31'd0, chain});
    @(negedge clk);
    chk({tag, "_done_single"}, {31'd0, done_s}, 32'd0);
    if (!chain) begin
      extra = 0;
      repeat (5) begin
        if (vld_s) extra++;
        @(negedge clk);
      end
      chk({tag, "_no_extra"}, extra, 0);
    end
  endtask

  initial begin
    int n;
    int vcnt;
    checks = 0;
    failures = 0;
    cur_sel = 1'b0;
    rst = 1'b1;
    bus_a.angle_in = '0; bus_a.angle_vld = 1'b0; bus_a.tx_rdy = 1'b0;
    bus_b.angle_in = '0; bus_b.angle_vld = 1'b0; bus_b.tx_rdy = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_tx_vld", {31'd0, bus_a.tx_vld}, 32'd0);
    chk("rst_busy", {31'd0, bus_a.busy}, 32'd0);
    chk("rst_done", {31'd0, bus_a.frame_done}, 32'd0);
    chk("rst_data", {24'd0, bus_a.tx_data}, 32'd0);
    chk("rst_drop", {24'd0, bus_a.drop_cnt}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    run_frame("t1_45", 0, 1, 16'd45, 64'h2B30303034350D0A, 8, 0, 0, 16'd0);
    run_frame("t2_m90", 0, 1, 16'hFFA6, 64'h2D30303039300D0A, 8, 0, 0, 16'd0);
    run_frame("t2_min", 0, 1, 16'h8000, 64'h2D33323736380D0A, 8, 0, 0, 16'd0);
    run_frame("t3_zero", 1, 1, 16'd0, 64'h2B20202020300000, 6, 0, 0, 16'd0);
    run_frame("t3_seven", 1, 1, 16'd7, 64'h2B20202020370000, 6, 0, 0, 16'd0);
    run_frame("t4_stall", 0, 1, 16'd12345, 64'h2B31323334350D0A, 8, 1, 0, 16'd0);

    // drops during CONV; frame keeps the captured value
    bus_a.tx_rdy = 1'b1;
    cur_sel = 1'b0;
    strobe(0, 16'd1000);
    repeat (3) strobe(0, 16'h1234);
    run_frame("t5_drop", 0, 0, 16'd0, 64'h2B30313030300D0A, 8, 0, 0, 16'd0);
    chk("t5_drop_cnt3", {24'd0, bus_a.drop_cnt}, 32'd3);
    run_frame("t5_chain_a", 0, 1, 16'd5, 64'h2B30303030350D0A, 8, 0, 1, 16'hFFFF);
    run_frame("t5_chain_b", 0, 0, 16'd0, 64'h2D30303030310D0A, 8, 0, 0, 16'd0);
    chk("t5_chain_nodrop", {24'd0, bus_a.drop_cnt}, 32'd3);

    bus_a.tx_rdy = 1'b0;
    strobe(0, 16'd9);
    bus_a.angle_vld = 1'b1;
    repeat (300) @(negedge clk);
    bus_a.angle_vld = 1'b0;
    chk("t5_drop_sat", {24'd0, bus_a.drop_cnt}, 32'd255);
    run_frame("t5_sat_frame", 0, 0, 16'd0, 64'h2B30303030390D0A, 8, 0, 0, 16'd0);

    // reset mid-frame after the third byte
    bus_a.tx_rdy = 1'b1;
    cur_sel = 1'b0;
    strobe(0, 16'd250);
    n = 0; vcnt = 0;
    while (n < 3 && vcnt < 200) begin
      if (bus_a.tx_vld && bus_a.tx_rdy) n++;
      @(negedge clk);
      vcnt++;
    end
    chk("t6_three_sent", n, 3);
    rst = 1'b1;
    #1;
    chk("t6_rst_vld", {31'd0, bus_a.tx_vld}, 32'd0);
    chk("t6_rst_busy", {31'd0, bus_a.busy}, 32'd0);
    chk("t6_rst_drop", {24'd0, bus_a.drop_cnt}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    vcnt = 0;
    repeat (30) begin
      @(negedge clk);
      if (bus_a.tx_vld) vcnt++;
    end
    chk("t6_quiet", vcnt, 0);
    run_frame("t6_after", 0, 1, 16'd777, 64'h2B30303737370D0A, 8, 0, 0, 16'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
